// File: rtl/shift_arbiter_if.sv
// Request, response and shifter-control bundle between two requesters,
// the shift arbiter and an external registered shifter.
interface shift_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NUMW  = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [NUMW-1:0]  req0_num;
    logic             req0_inbit;
    logic [WIDTH-1:0] req0_data;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [NUMW-1:0]  req1_num;
    logic             req1_inbit;
    logic [WIDTH-1:0] req1_data;

    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;

    logic             sh_load;
    logic             sh_rshift;
    logic             sh_lshift;
    logic [NUMW-1:0]  sh_shiftnum;
    logic             sh_inbit;
    logic [WIDTH-1:0] sh_in;
    logic [WIDTH-1:0] sh_out;

    logic             busy;

    modport slave (
        input  req0_valid, req0_op, req0_num, req0_inbit, req0_data,
        input  req1_valid, req1_op, req1_num, req1_inbit, req1_data,
        input  sh_out,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data,
        output sh_load, sh_rshift, sh_lshift, sh_shiftnum, sh_inbit, sh_in,
        output busy
    );

    modport master (
        output req0_valid, req0_op, req0_num, req0_inbit, req0_data,
        output req1_valid, req1_op, req1_num, req1_inbit, req1_data,
        output sh_out,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data,
        input  sh_load, sh_rshift, sh_lshift, sh_shiftnum, sh_inbit, sh_in,
        input  busy
    );
endinterface

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of a registered shifter: grant, issue one
// control cycle, return the shifter result. Define SHIFT_ARB_FIXPRI_EN for fixed priority.
//
// state | meaning
// IDLE  | waiting for a request, ready asserted for the granted requester
// ISSUE | drive one shifter control pulse from the latched request
// RESP  | return sh_out to the latched requester
module shift_arbiter #(
    parameter int WIDTH = 8,
    parameter int NUMW  = 3
) (
    input  logic          clk,
    input  logic          rst,
    shift_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q;
    logic [NUMW-1:0]  num_q;
    logic             inbit_q;
    logic [WIDTH-1:0] data_q;
    logic             id_q;
    logic             gnt_id;
    logic             accept;

`ifdef SHIFT_ARB_FIXPRI_EN
    always_comb gnt_id = !bus.req0_valid;
`else
    logic last_q;

    // last_q holds the most recent winner; reset value 1 lets req0 take the first tie
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) gnt_id = ~last_q;
        else                                  gnt_id = !bus.req0_valid;
    end

    always_ff @(posedge clk) begin
        if (rst)         last_q <= 1'b1;
        else if (accept) last_q <= gnt_id;
    end
`endif

    assign accept = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            num_q   <= '0;
            inbit_q <= 1'b0;
            data_q  <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                id_q    <= gnt_id;
                op_q    <= gnt_id ? bus.req1_op    : bus.req0_op;
                num_q   <= gnt_id ? bus.req1_num   : bus.req0_num;
                inbit_q <= gnt_id ? bus.req1_inbit : bus.req0_inbit;
                data_q  <= gnt_id ? bus.req1_data  : bus.req0_data;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.req0_ready  = 1'b0;
        bus.req1_ready  = 1'b0;
        bus.rsp_valid   = 1'b0;
        bus.rsp_id      = 1'b0;
        bus.rsp_data    = '0;
        bus.sh_load     = 1'b0;
        bus.sh_rshift   = 1'b0;
        bus.sh_lshift   = 1'b0;
        bus.sh_shiftnum = '0;
        bus.sh_inbit    = 1'b0;
        bus.sh_in       = '0;
        bus.busy        = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                bus.req0_ready = accept && !gnt_id;
                bus.req1_ready = accept && gnt_id;
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                bus.sh_load     = (op_q == 2'b01);
                bus.sh_rshift   = (op_q == 2'b10);
                bus.sh_lshift   = (op_q == 2'b11);
                bus.sh_shiftnum = num_q;
                bus.sh_inbit    = inbit_q;
                bus.sh_in       = data_q;
                state_d         = RESP;
            end
            RESP: begin
                // rsp is suppressed while rst is high so an aborted op never pulses
                bus.rsp_valid = !rst;
                bus.rsp_id    = rst ? 1'b0 : id_q;
                bus.rsp_data  = rst ? '0 : bus.sh_out;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a behavioural registered shifter.
module tb_shift_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_rr[4];

    always #5 clk = ~clk;

    shift_arbiter_if #(.WIDTH(8), .NUMW(3)) bus ();

    shift_arbiter #(.WIDTH(8), .NUMW(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // shifter model: fill bit enters from the vacated side
    logic [7:0] shreg = 8'h00;
    always_ff @(posedge clk) begin
        if (bus.sh_load) begin
            shreg <= bus.sh_in;
        end else if (bus.sh_rshift) begin
            shreg <= 8'(({{8{bus.sh_inbit}}, shreg}) >> bus.sh_shiftnum);
        end else if (bus.sh_lshift) begin
            shreg <= 8'(({shreg, {8{bus.sh_inbit}}} << bus.sh_shiftnum) >> 8);
        end
    end
    assign bus.sh_out = shreg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic v, input logic [1:0] op,
                           input logic [2:0] num, input logic b, input logic [7:0] d);
        if (id == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_num = num;
            bus.req0_inbit = b; bus.req0_data = d;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_num = num;
            bus.req1_inbit = b; bus.req1_data = d;
        end
    endtask

    task automatic wait_ready(input int id);
        int cyc = 0;
        @(negedge clk);
        while (!(id == 0 ? bus.req0_ready : bus.req1_ready) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("ready_seen", id == 0 ? bus.req0_ready : bus.req1_ready, 1);
    endtask

    task automatic run_op(input string tag, input int id, input logic [1:0] op,
                          input logic [2:0] num, input logic b, input logic [7:0] d,
                          input logic [7:0] exp);
        logic [2:0] exp_ctl;
        case (op)
            2'b01:   exp_ctl = 3'b100;
            2'b10:   exp_ctl = 3'b010;
            2'b11:   exp_ctl = 3'b001;
            default: exp_ctl = 3'b000;
        endcase
        @(posedge clk); #1;
        set_req(id, 1'b1, op, num, b, d);
        wait_ready(id);
        @(posedge clk); #1;
        set_req(id, 1'b0, 2'b00, 3'd0, 1'b0, 8'h00);
        @(negedge clk);
        chk({tag, "_issue_ctl"}, {bus.sh_load, bus.sh_rshift, bus.sh_lshift}, exp_ctl);
        chk({tag, "_issue_in"}, {bus.sh_in, 5'(bus.sh_shiftnum), 7'(bus.sh_inbit)},
            {d, 5'(num), 7'(b)});
        chk({tag, "_issue_busy"}, {bus.busy, bus.rsp_valid, bus.req0_ready, bus.req1_ready}, 4'b1000);
        @(negedge clk);
        chk({tag, "_rsp"}, {bus.rsp_valid, 7'(bus.rsp_id), bus.rsp_data}, {1'b1, 7'(id), exp});
        chk({tag, "_rsp_ctl"}, {bus.sh_load, bus.sh_rshift, bus.sh_lshift, bus.busy}, 4'b0001);
        @(negedge clk);
        chk({tag, "_done"}, {bus.rsp_valid, bus.busy, bus.rsp_data}, 10'h000);
    endtask

    initial begin
`ifdef SHIFT_ARB_FIXPRI_EN
        exp_rr = '{0, 0, 0, 0};
`else
        exp_rr = '{0, 1, 0, 1};
`endif
        set_req(0, 1'b0, 2'b00, 3'd0, 1'b0, 8'h00);
        set_req(1, 1'b0, 2'b00, 3'd0, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {bus.busy, bus.rsp_valid, bus.req0_ready, bus.req1_ready,
                            bus.sh_load, bus.sh_rshift, bus.sh_lshift}, 7'b0);
        chk("reset_sh_in", {bus.sh_in, bus.rsp_data}, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("load_aa",   0, 2'b01, 3'd0, 1'b0, 8'hAA, 8'hAA);
        run_op("rsh3",      1, 2'b10, 3'd3, 1'b1, 8'h00, 8'hF5);
        run_op("read",      0, 2'b00, 3'd5, 1'b1, 8'h11, 8'hF5);
        run_op("rsh0",      1, 2'b10, 3'd0, 1'b1, 8'h00, 8'hF5);
        run_op("lsh2",      0, 2'b11, 3'd2, 1'b0, 8'h00, 8'hD4);

        // fresh reset so the tie pointer starts from its reset value
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(0, 1'b1, 2'b00, 3'd0, 1'b0, 8'h00);
        set_req(1, 1'b1, 2'b00, 3'd0, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            int cyc = 0;
            @(negedge clk);
            while (!(bus.req0_ready || bus.req1_ready) && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            chk("rr_onehot", {bus.req0_ready, bus.req1_ready} == 2'b01 ||
                             {bus.req0_ready, bus.req1_ready} == 2'b10, 1);
            chk("rr_grant", bus.req1_ready, exp_rr[k]);
            @(posedge clk); #1;
        end
        set_req(0, 1'b0, 2'b00, 3'd0, 1'b0, 8'h00);
        set_req(1, 1'b0, 2'b00, 3'd0, 1'b0, 8'h00);
        repeat (3) @(posedge clk);

        // reset while in ISSUE aborts the op
        #1;
        set_req(0, 1'b1, 2'b01, 3'd0, 1'b0, 8'h3C);
        wait_ready(0);
        @(posedge clk); #1;
        set_req(0, 1'b0, 2'b00, 3'd0, 1'b0, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy_issue", {bus.busy, bus.rsp_valid}, 2'b10);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle", {bus.busy, bus.rsp_valid, bus.sh_load, bus.sh_rshift,
                           bus.sh_lshift, bus.sh_inbit}, 6'b0);
        chk("abort_sh_vals", {bus.sh_in, 5'(bus.sh_shiftnum)}, 13'h0);
        @(negedge clk);
        chk("abort_no_rsp", {bus.rsp_valid, bus.busy}, 2'b00);
        run_op("post_abort", 0, 2'b01, 3'd0, 1'b0, 8'h5A, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
